stage_mem: RTL and testbench

//  Memory-access pipeline stage; the consumer of the execute stage's outputs. Registers the EX/MEM

---
 rtl/stage_mem.sv | 176 +++++++++++++++++
 tb/tb_stage_mem.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// stage_mem: EX/MEM register, branch redirect, data-memory req/ack access with load alignment, MEM/WB register.
// Optional macro MEM_MISALIGN_TRAP_EN suppresses misaligned H/W accesses and raises misalign.
module stage_mem #(
  parameter int reg_addr_width = 5,
  parameter int ins_addr_width = 32,
  parameter int word_width     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [word_width-1:0]     rslt_in,
  input  logic [word_width-1:0]     rs2_val_in,
  input  logic [ins_addr_width-1:0] tgt_addr_in,
  input  logic [word_width-1:0]     imm_ext_in,
  input  logic [reg_addr_width-1:0] rd_addr_in,
  input  logic                      jmp_ctl_in,
  input  logic                      bch_ctl_in,
  input  logic                      mem_ctl_in,
  input  logic                      rd_wen_in,
  input  logic [1:0]                wb_ctl_in,
  input  logic [2:0]                byt_typ_in,
  output logic [ins_addr_width-1:0] dmem_addr,
  output logic [word_width-1:0]     dmem_wdata,
  output logic [3:0]                dmem_be,
  output logic                      dmem_req,
  output logic                      dmem_we,
  input  logic [word_width-1:0]     dmem_rdata,
  input  logic                      dmem_ack,
  output logic                      stall,
  output logic                      redirect,
  output logic [ins_addr_width-1:0] redirect_addr,
  output logic                      mem_wen,
  output logic [reg_addr_width-1:0] mem_rd,
  output logic [word_width-1:0]     mem_d,
  output logic                      wb_wen_out,
  output logic [reg_addr_width-1:0] wb_rd_out,
  output logic [word_width-1:0]     wb_d_out,
  output logic                      misalign
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state_q;
  logic [word_width-1:0]     rslt_q, rs2_q, imm_q;
  logic [ins_addr_width-1:0] tgt_q;
  logic [reg_addr_width-1:0] rd_q;
  logic                      jmp_q, bch_q, mem_q, rdwen_q;
  logic [1:0]                wbctl_q;
  logic [2:0]                typ_q;

  logic                      wb_wen_q;
  logic [reg_addr_width-1:0] wb_rd_q;
  logic [word_width-1:0]     wb_d_q;

  logic                      is_byte, is_half, is_word, is_signed;
  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;
  logic [word_width-1:0]     load_val, wb_val;

  assign is_byte   = (typ_q == 3'b000) || (typ_q == 3'b100);
  assign is_half   = (typ_q == 3'b001) || (typ_q == 3'b101);
  assign is_word   = ~is_byte & ~is_half;
  assign is_signed = ~typ_q[2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_q & ((is_half & rslt_q[0]) | (is_word & (rslt_q[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // The stage register is frozen while stalled, so address/data/enables stay stable through BUSY.
  assign dmem_req  = (state_q == BUSY) | (mem_q & ~misalign);
  assign dmem_we   = dmem_req & ~rdwen_q;
  assign stall     = dmem_req & ~dmem_ack;
  assign dmem_addr = {rslt_q[ins_addr_width-1:2], 2'b00};

  always_comb begin
    dmem_wdata = rs2_q;
    dmem_be    = 4'b1111;
    if (!rdwen_q) begin
      if (is_byte) begin
        dmem_wdata = {4{rs2_q[7:0]}};
        dmem_be    = 4'b0001 << rslt_q[1:0];
      end else if (is_half) begin
        dmem_wdata = {2{rs2_q[15:0]}};
        dmem_be    = rslt_q[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  always_comb begin
    case (rslt_q[1:0])
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = rslt_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    if (is_byte)
      load_val = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
    else if (is_half)
      load_val = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
    else
      load_val = dmem_rdata;
  end

  always_comb begin
    case (wbctl_q)
      2'b01:   wb_val = load_val;
      2'b10:   wb_val = imm_q;
      default: wb_val = rslt_q;
    endcase
  end

  // Loads are never forwarded from here; the load-use hazard is stalled upstream.
  assign mem_wen       = rdwen_q & ~mem_q & (rd_q != '0);
  assign mem_rd        = rd_q;
  assign mem_d         = wb_val;
  assign redirect      = jmp_q | (bch_q & rslt_q[0]);
  assign redirect_addr = tgt_q;

  assign wb_wen_out = wb_wen_q;
  assign wb_rd_out  = wb_rd_q;
  assign wb_d_out   = wb_d_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rslt_q  <= '0;
      rs2_q   <= '0;
      tgt_q   <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      jmp_q   <= 1'b0;
      bch_q   <= 1'b0;
      mem_q   <= 1'b0;
      rdwen_q <= 1'b0;
      wbctl_q <= 2'b00;
      typ_q   <= 3'b000;
    end else if (!stall) begin
      rslt_q  <= rslt_in;
      rs2_q   <= rs2_val_in;
      tgt_q   <= tgt_addr_in;
      imm_q   <= imm_ext_in;
      rd_q    <= rd_addr_in;
      jmp_q   <= jmp_ctl_in;
      bch_q   <= bch_ctl_in;
      mem_q   <= mem_ctl_in;
      rdwen_q <= rd_wen_in;
      wbctl_q <= wb_ctl_in;
      typ_q   <= byt_typ_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (dmem_req && !dmem_ack) state_q <= BUSY;
        default: if (dmem_ack) state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_wen_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_d_q   <= '0;
    end else begin
      wb_wen_q <= rdwen_q & ~stall & (rd_q != '0) & ~misalign;
      wb_rd_q  <= rd_q;
      wb_d_q   <= wb_val;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Randomized bench for stage_mem against a transaction-level reference model.
module tb_stage_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rslt_in, rs2_val_in, tgt_addr_in, imm_ext_in;
  logic [4:0]  rd_addr_in;
  logic        jmp_ctl_in, bch_ctl_in, mem_ctl_in, rd_wen_in;
  logic [1:0]  wb_ctl_in;
  logic [2:0]  byt_typ_in;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        stall, redirect, mem_wen, wb_wen_out, misalign;
  logic [31:0] redirect_addr, mem_d, wb_d_out;
  logic [4:0]  mem_rd, wb_rd_out;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  always #5 clk = ~clk;

  stage_mem dut (
    .clk(clk), .rst(rst),
    .rslt_in(rslt_in), .rs2_val_in(rs2_val_in), .tgt_addr_in(tgt_addr_in),
    .imm_ext_in(imm_ext_in), .rd_addr_in(rd_addr_in),
    .jmp_ctl_in(jmp_ctl_in), .bch_ctl_in(bch_ctl_in), .mem_ctl_in(mem_ctl_in),
    .rd_wen_in(rd_wen_in), .wb_ctl_in(wb_ctl_in), .byt_typ_in(byt_typ_in),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_d(mem_d),
    .wb_wen_out(wb_wen_out), .wb_rd_out(wb_rd_out), .wb_d_out(wb_d_out),
    .misalign(misalign)
  );

  typedef struct {
    logic [31:0] rslt, rs2, tgt, imm;
    logic [4:0]  rd;
    logic        jmp, bch, mem, rdwen;
    logic [1:0]  wbctl;
    logic [2:0]  typ;
  } instr_t;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(input logic [31:0] rslt, rs2, tgt, imm, input logic [4:0] rd,
                                input logic jmp, bch, mem, rdwen,
                                input logic [1:0] wbctl, input logic [2:0] typ);
    instr_t t;
    t.rslt = rslt; t.rs2 = rs2; t.tgt = tgt; t.imm = imm; t.rd = rd;
    t.jmp = jmp; t.bch = bch; t.mem = mem; t.rdwen = rdwen; t.wbctl = wbctl; t.typ = typ;
    return t;
  endfunction

  task automatic drive(input instr_t t);
    rslt_in = t.rslt; rs2_val_in = t.rs2; tgt_addr_in = t.tgt; imm_ext_in = t.imm;
    rd_addr_in = t.rd; jmp_ctl_in = t.jmp; bch_ctl_in = t.bch; mem_ctl_in = t.mem;
    rd_wen_in = t.rdwen; wb_ctl_in = t.wbctl; byt_typ_in = t.typ;
  endtask

  function automatic int access_size(input logic [2:0] typ);
    if (typ == 3'd0 || typ == 3'd4) return 1;
    if (typ == 3'd1 || typ == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic model_misalign(input instr_t t);
`ifdef MEM_MISALIGN_TRAP_EN
    int sz = access_size(t.typ);
    return t.mem && ((sz == 2 && (t.rslt % 2) != 0) || (sz == 4 && (t.rslt % 4) != 0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input instr_t t, input logic [31:0] rd_word);
    int          sz = access_size(t.typ);
    logic        sgn = (t.typ == 3'd0) || (t.typ == 3'd1);
    logic [31:0] v;
    if (sz == 1) begin
      v = (rd_word >> ((t.rslt % 4) * 8)) & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = (rd_word >> (((t.rslt / 2) % 2) * 16)) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = rd_word;
    end
    return v;
  endfunction

  // Present one instruction, let it enter the stage, ack after wait_c cycles, then check writeback.
  task automatic exec(input string name, input instr_t t, input int wait_c, input logic [31:0] rdata_v);
    instr_t      bub = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
    int          sz = access_size(t.typ);
    logic        mis = model_misalign(t);
    logic        req = t.mem && !mis;
    logic        is_load = t.mem && t.rdwen;
    logic        red = t.jmp || (t.bch && t.rslt[0]);
    logic        fwd = t.rdwen && !t.mem && (t.rd != 0);
    logic        wen = t.rdwen && (t.rd != 0) && !mis;
    logic [31:0] fwd_d = (t.wbctl == 2'b10) ? t.imm : t.rslt;
    logic [31:0] exp_wd, exp_be, wb_exp;
    int          k;
    if (is_load) exp_be = 32'hF;
    else if (sz == 1) exp_be = 32'h1 << (t.rslt % 4);
    else if (sz == 2) exp_be = ((t.rslt / 2) % 2 != 0) ? 32'hC : 32'h3;
    else exp_be = 32'hF;
    if (sz == 1) exp_wd = (t.rs2 & 32'hFF) * 32'h01010101;
    else if (sz == 2) exp_wd = (t.rs2 & 32'hFFFF) * 32'h00010001;
    else exp_wd = t.rs2;
    wb_exp = (t.wbctl == 2'b01) ? model_load(t, rdata_v) : fwd_d;

    @(negedge clk);
    drive(t);
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    drive(bub);
    k = 0;
    while (1) begin
      dmem_ack   = req && (k == wait_c);
      dmem_rdata = (k == wait_c) ? rdata_v : $urandom;
      #1;
      chk_val({name, ".req"}, {31'b0, dmem_req}, {31'b0, req});
      chk_val({name, ".stall"}, {31'b0, stall}, {31'b0, req && (k < wait_c)});
      chk_val({name, ".misalign"}, {31'b0, misalign}, {31'b0, mis});
      chk_val({name, ".redirect"}, {31'b0, redirect}, {31'b0, red});
      if (red) chk_val({name, ".redir_addr"}, redirect_addr, t.tgt);
      chk_val({name, ".mem_wen"}, {31'b0, mem_wen}, {31'b0, fwd});
      chk_val({name, ".mem_rd"}, {27'b0, mem_rd}, {27'b0, t.rd});
      if (fwd) chk_val({name, ".mem_d"}, mem_d, fwd_d);
      chk_val({name, ".wb_bubble"}, {31'b0, wb_wen_out}, 32'd0);
      if (req) begin
        chk_val({name, ".addr"}, dmem_addr, t.rslt & 32'hFFFFFFFC);
        chk_val({name, ".we"}, {31'b0, dmem_we}, {31'b0, !t.rdwen});
        chk_val({name, ".be"}, {28'b0, dmem_be}, exp_be);
        if (!t.rdwen) chk_val({name, ".wdata"}, dmem_wdata, exp_wd);
      end
      @(posedge clk); #1;
      if (!req || k >= wait_c) break;
      k++;
    end
    dmem_ack = 1'b0;
    chk_val({name, ".wb_wen"}, {31'b0, wb_wen_out}, {31'b0, wen});
    if (wen) begin
      chk_val({name, ".wb_rd"}, {27'b0, wb_rd_out}, {27'b0, t.rd});
      chk_val({name, ".wb_d"}, wb_d_out, wb_exp);
    end
    chk_val({name, ".redirect_off"}, {31'b0, redirect}, 32'd0);
    n_txn++;
    $display("txn %0d %s a=0x%08h rd=%0d wait=%0d req=%0b mis=%0b wb=%0b/0x%08h",
             n_txn, name, t.rslt, t.rd, wait_c, req, mis, wen, wb_exp);
  endtask

  task automatic reset_mid_busy();
    instr_t lw = mk(32'h200, 0, 0, 0, 5'd3, 0, 0, 1, 1, 2'b01, 3'b010);
    @(negedge clk);
    drive(lw);
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000));
    #1;
    chk_val("rst_busy.req_before", {31'b0, dmem_req}, 32'd1);
    chk_val("rst_busy.stall_before", {31'b0, stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_val("rst_busy.req", {31'b0, dmem_req}, 32'd0);
    chk_val("rst_busy.stall", {31'b0, stall}, 32'd0);
    chk_val("rst_busy.addr", dmem_addr, 32'd0);
    chk_val("rst_busy.wb_wen", {31'b0, wb_wen_out}, 32'd0);
    chk_val("rst_busy.wb_d", wb_d_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    chk_val("late_ack.req", {31'b0, dmem_req}, 32'd0);
    chk_val("late_ack.stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk_val("late_ack.req_after", {31'b0, dmem_req}, 32'd0);
    chk_val("late_ack.wb_wen", {31'b0, wb_wen_out}, 32'd0);
    n_txn++;
    $display("txn %0d reset_mid_busy", n_txn);
  endtask

  initial begin
    instr_t t;
    int     kind, w;
    logic [2:0] ltyp [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000));
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_val("reset.req", {31'b0, dmem_req}, 32'd0);
    chk_val("reset.stall", {31'b0, stall}, 32'd0);
    chk_val("reset.redirect", {31'b0, redirect}, 32'd0);
    chk_val("reset.wb_wen", {31'b0, wb_wen_out}, 32'd0);
    chk_val("reset.wb_d", wb_d_out, 32'd0);
    chk_val("reset.addr", dmem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    exec("SW",   mk(32'h100, 32'hDEADBEEF, 0, 0, 5'd7, 0, 0, 1, 0, 2'b00, 3'b010), 0, 32'h0);
    exec("SB",   mk(32'h103, 32'h000000AB, 0, 0, 5'd0, 0, 0, 1, 0, 2'b00, 3'b000), 1, 32'h0);
    exec("SH",   mk(32'h102, 32'h1234BEEF, 0, 0, 5'd0, 0, 0, 1, 0, 2'b00, 3'b001), 0, 32'h0);
    exec("LB",   mk(32'h102, 0, 0, 0, 5'd9, 0, 0, 1, 1, 2'b01, 3'b000), 3, 32'h00800000);
    exec("LBU",  mk(32'h102, 0, 0, 0, 5'd9, 0, 0, 1, 1, 2'b01, 3'b100), 3, 32'h00800000);
    exec("LH1",  mk(32'h101, 0, 0, 0, 5'd4, 0, 0, 1, 1, 2'b01, 3'b001), 1, 32'h8001F00F);
    exec("LW",   mk(32'h204, 0, 0, 0, 5'd12, 0, 0, 1, 1, 2'b01, 3'b010), 2, 32'h13579BDF);
    exec("ALU",  mk(32'h1234, 0, 0, 0, 5'd5, 0, 0, 0, 1, 2'b00, 3'b000), 0, 32'h0);
    exec("ALU0", mk(32'h5678, 0, 0, 0, 5'd0, 0, 0, 0, 1, 2'b00, 3'b000), 0, 32'h0);
    exec("LUI",  mk(32'h1, 0, 0, 32'hABCD0000, 5'd6, 0, 0, 0, 1, 2'b10, 3'b000), 0, 32'h0);
    exec("BT",   mk(32'h1, 0, 32'h40, 0, 5'd0, 0, 1, 0, 0, 2'b00, 3'b000), 0, 32'h0);
    exec("BNT",  mk(32'h0, 0, 32'h80, 0, 5'd0, 0, 1, 0, 0, 2'b00, 3'b000), 0, 32'h0);
    exec("JAL",  mk(32'h44, 0, 32'h1000, 0, 5'd1, 1, 0, 0, 1, 2'b00, 3'b000), 0, 32'h0);
    reset_mid_busy();
    exec("ALU_after_rst", mk(32'h9999, 0, 0, 0, 5'd8, 0, 0, 0, 1, 2'b11, 3'b000), 0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 5);
      w = $urandom_range(0, 3);
      case (kind)
        0: t = mk($urandom, 0, 0, $urandom, 5'($urandom), 0, 0, 0, 1'($urandom),
                  ($urandom_range(0, 2) == 0) ? 2'b10 : 2'($urandom_range(0, 1) * 3), 3'($urandom));
        1: t = mk($urandom, 0, $urandom, 0, 5'd0, 0, 1, 0, 0, 2'b00, 3'b000);
        2: t = mk($urandom, 0, $urandom, 0, 5'($urandom), 1, 0, 0, 1, 2'b00, 3'b000);
        3, 4: t = mk($urandom, 0, 0, 0, 5'($urandom), 0, 0, 1, 1, 2'b01,
                     ltyp[$urandom_range(0, 7)]);
        default: t = mk($urandom, $urandom, 0, 0, 5'($urandom), 0, 0, 1, 0, 2'b00,
                        3'($urandom_range(0, 2)));
      endcase
      exec($sformatf("rnd%0d", i), t, w, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
